// File: rtl/mine_quest_pkg.sv
// Shared types and constants for the mine-quest timer display: FSM states,
// time field width, double-dabble step and seven-segment patterns.
package mine_quest_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    localparam int unsigned TIME_W = 7;
    // Shift register layout per field: {hundreds carry, tens, units, binary}
    localparam int unsigned DD_W   = 1 + 4 + 4 + TIME_W;
    localparam int unsigned ITER_W = 3;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] s);
        logic [DD_W-1:0] t;
        t = s;
        if (t[TIME_W +: 4] >= 4'd5)
            t[TIME_W +: 4] = t[TIME_W +: 4] + 4'd3;
        if (t[TIME_W+4 +: 4] >= 4'd5)
            t[TIME_W+4 +: 4] = t[TIME_W+4 +: 4] + 4'd3;
        return {t[DD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern (gfedcba); the dash flag
// overrides the digit for out-of-range fields.
module seg7_decoder
    import mine_quest_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (dash_i) begin
            seg_o = SEG_DASH;
        end else begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/timer_display.sv
// Converts hours/minutes/seconds to six seven-segment digits with a serial
// double-dabble pass on every input change, and blinks while the game is over.
module timer_display
    import mine_quest_pkg::*;
#(
    parameter int unsigned BLINK_HALF_PERIOD = 250000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [TIME_W-1:0] seconds,
    input  logic [TIME_W-1:0] minutes,
    input  logic [TIME_W-1:0] hours,
    input  logic              is_game_over,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5,
    output logic              busy
);

    localparam int unsigned CW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;

    state_t                state_q, state_d;
    logic [3*TIME_W-1:0]   snap_q, snap_d;
    logic [ITER_W-1:0]     iter_q, iter_d;
    logic [DD_W-1:0]       sh_q [3];
    logic [DD_W-1:0]       sh_d [3];
    logic [6:0]            seg_q [6];
    logic [6:0]            seg_d [6];
    logic                  busy_q;
    logic [CW-1:0]         blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic [3*TIME_W-1:0]   cur;
    logic [6:0]            dec_seg [6];

    assign cur = {hours, minutes, seconds};

    // Digit index 2f is units, 2f+1 is tens; the hundreds carry drives the dash.
    for (genvar f = 0; f < 3; f++) begin : g_field
        seg7_decoder u_units (
            .bcd_i  (sh_q[f][TIME_W +: 4]),
            .dash_i (sh_q[f][DD_W-1]),
            .seg_o  (dec_seg[2*f])
        );
        seg7_decoder u_tens (
            .bcd_i  (sh_q[f][TIME_W+4 +: 4]),
            .dash_i (sh_q[f][DD_W-1]),
            .seg_o  (dec_seg[2*f+1])
        );
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        iter_d  = iter_q;
        sh_d    = sh_q;
        seg_d   = seg_q;
        case (state_q)
            IDLE: begin
                if (cur != snap_q) begin
                    snap_d = cur;
                    for (int unsigned f = 0; f < 3; f++)
                        sh_d[f] = {{(DD_W-TIME_W){1'b0}}, cur[f*TIME_W +: TIME_W]};
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int unsigned f = 0; f < 3; f++)
                    sh_d[f] = dd_step(sh_q[f]);
                iter_d = iter_q + 1'b1;
                if (iter_q == ITER_W'(TIME_W-1))
                    state_d = UPDATE;
            end
            UPDATE: begin
                for (int unsigned i = 0; i < 6; i++)
                    seg_d[i] = dec_seg[i];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (is_game_over) begin
            phase_d = phase_q;
            if (blink_cnt_q == CW'(BLINK_HALF_PERIOD-1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            iter_q      <= '0;
            sh_q        <= '{default: '0};
            seg_q       <= '{default: SEG_0};
            busy_q      <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            iter_q      <= iter_d;
            sh_q        <= sh_d;
            seg_q       <= seg_d;
            busy_q      <= (state_d != IDLE);
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        HEX0 = phase_q ? SEG_BLANK : seg_q[0];
        HEX1 = phase_q ? SEG_BLANK : seg_q[1];
        HEX2 = phase_q ? SEG_BLANK : seg_q[2];
        HEX3 = phase_q ? SEG_BLANK : seg_q[3];
        HEX4 = phase_q ? SEG_BLANK : seg_q[4];
        HEX5 = phase_q ? SEG_BLANK : seg_q[5];
    end

    assign busy = busy_q;

endmodule
